// File: rtl/spi_fifo_pkg.sv
// Shared types and helpers for the watermark FIFO: count-change encoding and the
// explicit pointer wrap used because depth need not be a power of two.
package spi_fifo_pkg;

  localparam int unsigned SPI_FIFO_MIN_DEPTH = 2;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  // Wraps to zero after depth-1 instead of relying on modulo-2^n overflow.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned depth);
    if (ptr == depth - 1) begin
      return '0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/spi_fifo_ptr.sv
// Wrapping FIFO pointer: advances by one when en_i is high, 0 after DEPTH-1; clr_i wins.
// Registered output, no backpressure of its own.
module spi_fifo_ptr
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = PTR_W'(next_ptr(32'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/spi_fifo_wm.sv
// Single-clock FIFO (any depth >= 2) with watermarks, free count and sticky overflow; one-cycle
// write-to-read latency, writes refused while full. Peak-occupancy tracker under SPI_FIFO_PEAK_EN.
module spi_fifo_wm
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  ovf_clr_i,
  input  logic [CNT_W-1:0]      afull_thr_i,
  input  logic [CNT_W-1:0]      aempty_thr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      elements_o,
  output logic [CNT_W-1:0]      free_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o
`ifdef SPI_FIFO_PEAK_EN
  ,
  output logic [CNT_W-1:0]      peak_o
`endif
);

  localparam int unsigned      PTR_W   = $clog2(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);

  if (BUFFER_DEPTH < SPI_FIFO_MIN_DEPTH) begin : g_depth_chk
    $error("spi_fifo_wm: BUFFER_DEPTH must be at least 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_d, count_q;
  logic                  ovf_d, ovf_q;
  logic                  full, empty, push, pop, wr_en, rd_en;
  cnt_op_e               cnt_op;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  // A pop in the same cycle does not make room for a push while full.
  assign push  = valid_i && !full;
  assign pop   = ready_i && !empty;
  assign wr_en = push && !clr_i;
  assign rd_en = pop && !clr_i;

  spi_fifo_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .en_i   (wr_en),
    .ptr_o  (wr_ptr)
  );

  spi_fifo_ptr #(
    .DEPTH (BUFFER_DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .en_i   (rd_en),
    .ptr_o  (rd_ptr)
  );

  always_comb begin
    cnt_op = CNT_HOLD;
    if (wr_en && !rd_en) begin
      cnt_op = CNT_INC;
    end else if (rd_en && !wr_en) begin
      cnt_op = CNT_DEC;
    end
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (cnt_op)
        CNT_INC: count_d = count_q + CNT_W'(1);
        CNT_DEC: count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // Set beats the overflow-only clear when both land in one cycle.
      if (valid_i && full) begin
        ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

`ifdef SPI_FIFO_PEAK_EN
  logic [CNT_W-1:0] peak_d, peak_q;

  always_comb begin
    peak_d = peak_q;
    if (clr_i) begin
      peak_d = '0;
    end else if (count_q > peak_q) begin
      peak_d = count_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`endif

  // Gated so the unreset storage never leaks onto data_o while empty.
  assign data_o         = empty ? '0 : mem_q[rd_ptr];
  assign valid_o        = !empty;
  assign ready_o        = !full;
  assign elements_o     = count_q;
  assign free_o         = DEPTH_C - count_q;
  assign almost_full_o  = (count_q >= afull_thr_i);
  assign almost_empty_o = (count_q <= aempty_thr_i);
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_spi_fifo_wm.sv
// Directed bench for spi_fifo_wm: depth-5 instance for data path and flags,
// depth-8 instance for the watermark sweep (and peak tracking when SPI_FIFO_PEAK_EN is defined).
module tb_spi_fifo_wm;

  logic clk;
  logic rst_n;

  logic       c5, oc5, v5, r5;
  logic [7:0] d5, do5;
  logic [2:0] a5f, a5e, el5, fr5;
  logic       rdy5, vo5, af5, ae5, ov5;

  logic       c8, oc8, v8, r8;
  logic [7:0] d8, do8;
  logic [3:0] a8f, a8e, el8, fr8;
  logic       rdy8, vo8, af8, ae8, ov8;

`ifdef SPI_FIFO_PEAK_EN
  logic [2:0] pk5;
  logic [3:0] pk8;
`endif

  int errors = 0;
  int checks = 0;

  spi_fifo_wm #(.DATA_WIDTH(8), .BUFFER_DEPTH(5)) u5 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(c5), .ovf_clr_i(oc5),
    .afull_thr_i(a5f), .aempty_thr_i(a5e),
    .valid_i(v5), .data_i(d5), .ready_o(rdy5),
    .data_o(do5), .valid_o(vo5), .ready_i(r5),
    .elements_o(el5), .free_o(fr5),
    .almost_full_o(af5), .almost_empty_o(ae5), .overflow_o(ov5)
`ifdef SPI_FIFO_PEAK_EN
    , .peak_o(pk5)
`endif
  );

  spi_fifo_wm #(.DATA_WIDTH(8), .BUFFER_DEPTH(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(c8), .ovf_clr_i(oc8),
    .afull_thr_i(a8f), .aempty_thr_i(a8e),
    .valid_i(v8), .data_i(d8), .ready_o(rdy8),
    .data_o(do8), .valid_o(vo8), .ready_i(r8),
    .elements_o(el8), .free_o(fr8),
    .almost_full_o(af8), .almost_empty_o(ae8), .overflow_o(ov8)
`ifdef SPI_FIFO_PEAK_EN
    , .peak_o(pk8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    c5 = 0; oc5 = 0; v5 = 0; r5 = 0; d5 = '0; a5f = 3'd4; a5e = 3'd1;
    c8 = 0; oc8 = 0; v8 = 0; r8 = 0; d8 = '0; a8f = 4'd6; a8e = 4'd2;
    #3;
    chk("rst_elements", 32'(el5), 32'd0);
    chk("rst_free",     32'(fr5), 32'd5);
    chk("rst_valid",    32'(vo5), 32'd0);
    chk("rst_ready",    32'(rdy5), 32'd1);
    chk("rst_overflow", 32'(ov5), 32'd0);
    chk("rst_data",     32'(do5), 32'd0);
`ifdef SPI_FIFO_PEAK_EN
    chk("rst_peak",     32'(pk5), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Fill depth-5 with A0..A4, consumer stalled.
    for (int i = 0; i < 5; i++) begin
      v5 = 1'b1;
      d5 = 8'(8'hA0 + i);
      tick();
      if (i == 3) begin
        chk("fill4_elements", 32'(el5), 32'd4);
        chk("fill4_afull",    32'(af5), 32'd1);
        chk("fill4_ready",    32'(rdy5), 32'd1);
      end
    end
    v5 = 1'b0;
    chk("full_elements", 32'(el5), 32'd5);
    chk("full_free",     32'(fr5), 32'd0);
    chk("full_ready",    32'(rdy5), 32'd0);
    chk("full_afull",    32'(af5), 32'd1);
    chk("full_aempty",   32'(ae5), 32'd0);

    r5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", 32'(vo5), 32'd1);
      chk("drain_data",  32'(do5), 32'(8'hA0 + i));
      tick();
    end
    r5 = 1'b0;
    chk("drained_valid",    32'(vo5), 32'd0);
    chk("drained_elements", 32'(el5), 32'd0);
    chk("drained_aempty",   32'(ae5), 32'd1);

    // Stream 13 words with both sides always ready; pointers wrap past 4.
    for (int k = 0; k < 13; k++) begin
      v5 = 1'b1;
      r5 = 1'b1;
      d5 = 8'(8'hB0 + k);
      tick();
      chk("stream_data",     32'(do5), 32'(8'hB0 + k));
      chk("stream_elements", 32'(el5), 32'd1);
    end
    v5 = 1'b0;
    tick();
    r5 = 1'b0;
    chk("stream_end_elements", 32'(el5), 32'd0);

    // Overflow: push+pop while full rejects the push.
    for (int i = 0; i < 5; i++) begin
      v5 = 1'b1;
      d5 = 8'(8'hC0 + i);
      tick();
    end
    d5 = 8'hCF;
    r5 = 1'b1;
    tick();
    v5 = 1'b0;
    r5 = 1'b0;
    chk("ovf_set",      32'(ov5), 32'd1);
    chk("ovf_elements", 32'(el5), 32'd4);
    chk("ovf_head",     32'(do5), 32'hC1);
    oc5 = 1'b1;
    tick();
    oc5 = 1'b0;
    chk("ovf_clear", 32'(ov5), 32'd0);
    v5 = 1'b1;
    d5 = 8'hC5;
    tick();
    chk("refill_elements", 32'(el5), 32'd5);
    oc5 = 1'b1;
    tick();
    v5 = 1'b0;
    oc5 = 1'b0;
    chk("ovf_set_wins", 32'(ov5), 32'd1);
    chk("ovf_set_wins_elements", 32'(el5), 32'd5);
    tick();
    chk("ovf_sticky", 32'(ov5), 32'd1);

    // clr_i flushes everything and discards a same-cycle write.
    c5 = 1'b1;
    tick();
    c5 = 1'b0;
    chk("clr_overflow", 32'(ov5), 32'd0);
    chk("clr_elements", 32'(el5), 32'd0);
    for (int i = 0; i < 3; i++) begin
      v5 = 1'b1;
      d5 = 8'(8'hD0 + i);
      tick();
    end
    d5 = 8'hDD;
    c5 = 1'b1;
    tick();
    c5 = 1'b0;
    chk("clrw_elements", 32'(el5), 32'd0);
    chk("clrw_valid",    32'(vo5), 32'd0);
    chk("clrw_overflow", 32'(ov5), 32'd0);
    chk("clrw_free",     32'(fr5), 32'd5);
    d5 = 8'h55;
    tick();
    v5 = 1'b0;
    chk("post_clr_data",     32'(do5), 32'h55);
    chk("post_clr_elements", 32'(el5), 32'd1);
    r5 = 1'b1;
    tick();
    r5 = 1'b0;
    chk("post_clr_drained", 32'(el5), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin
      v5 = 1'b1;
      d5 = 8'(8'hE0 + i);
      tick();
    end
    v5 = 1'b0;
    chk("pre_arst_elements", 32'(el5), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_elements", 32'(el5), 32'd0);
    chk("arst_valid",    32'(vo5), 32'd0);
    chk("arst_ready",    32'(rdy5), 32'd1);
    chk("arst_free",     32'(fr5), 32'd5);
    chk("arst_data",     32'(do5), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_no_residual", 32'(vo5), 32'd0);

    // Watermark sweep on depth 8: aempty=2, afull=6.
    for (int c = 0; c <= 8; c++) begin
      chk("sweep_up_elements", 32'(el8), 32'(c));
      chk("sweep_up_aempty",   32'(ae8), 32'(c <= 2));
      chk("sweep_up_afull",    32'(af8), 32'(c >= 6));
      if (c < 8) begin
        v8 = 1'b1;
        d8 = 8'(8'h10 + c);
        tick();
      end
    end
    v8 = 1'b0;
    chk("d8_full_ready", 32'(rdy8), 32'd0);
    chk("d8_full_free",  32'(fr8), 32'd0);
    a8e = 4'd8;
    #1;
    chk("aempty_thr_depth_forces", 32'(ae8), 32'd1);
    a8e = 4'd2;
    #1;
    for (int c = 8; c >= 0; c--) begin
      chk("sweep_dn_elements", 32'(el8), 32'(c));
      chk("sweep_dn_aempty",   32'(ae8), 32'(c <= 2));
      chk("sweep_dn_afull",    32'(af8), 32'(c >= 6));
      if (c > 0) begin
        chk("sweep_dn_data", 32'(do8), 32'(8'h10 + (8 - c)));
        r8 = 1'b1;
        tick();
      end
    end
    r8 = 1'b0;
    a8f = 4'd0;
    #1;
    chk("afull_thr_zero_forces", 32'(af8), 32'd1);
    a8f = 4'd6;
    #1;
`ifdef SPI_FIFO_PEAK_EN
    chk("peak_after_sweep", 32'(pk8), 32'd8);
    c8 = 1'b1;
    tick();
    c8 = 1'b0;
    chk("peak_after_clr", 32'(pk8), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_fifo_wm.md
Name: spi_fifo_wm

Overview:
- Parametrised successor to the SPI master TX/RX buffer: synchronous single-clock FIFO with arbitrary (non-power-of-two) depth.
- Adds runtime watermark thresholds, free-space count, a sticky overflow flag and an explicit clear. An optional peak-occupancy tracker can be compiled in.
- Sits between the AXI/register side and the SPI shift engine on both TX and RX paths, so the controller can raise interrupts and DMA requests on watermarks.

Parameters:
- DATA_WIDTH, 32, width of a data word.
- BUFFER_DEPTH, 8, number of entries; any value >= 2, power of two not required.
- CNT_W, $clog2(BUFFER_DEPTH+1), width of the occupancy, free-space and threshold fields.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous flush of contents and flags.
- ovf_clr_i  in  1  synchronous clear of overflow_o only.
- afull_thr_i  in  CNT_W  almost-full threshold, quasi-static.
- aempty_thr_i  in  CNT_W  almost-empty threshold, quasi-static.
- valid_i  in  1  write request.
- data_i  in  DATA_WIDTH  write data.
- ready_o  out  1  FIFO not full.
- data_o  out  DATA_WIDTH  head-of-FIFO data.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts the head word.
- elements_o  out  CNT_W  current occupancy.
- free_o  out  CNT_W  equals BUFFER_DEPTH - elements_o.
- almost_full_o  out  1  elements_o >= afull_thr_i.
- almost_empty_o  out  1  elements_o <= aempty_thr_i.
- overflow_o  out  1  sticky: a write was attempted while full.
- peak_o  out  CNT_W  maximum occupancy seen; present only with the optional feature.

Behaviour:
- Reset (async, rst_ni=0) values:
  - elements_o=0, free_o=BUFFER_DEPTH, valid_o=0, ready_o=1.
  - overflow_o=0, peak_o=0, data_o=0.
  - Read and write pointers=0; storage array is not reset.
- Push = valid_i && ready_o. Pop = ready_i && valid_o.
- ready_o = !full. A push while full is never accepted, even if a pop happens in the same cycle; this matches the previous generation.
- Latency:
  - First-word fall-through is not provided. A word written in cycle N appears on data_o/valid_o in cycle N+1.
  - data_o is driven combinationally from storage at the read pointer. It is don't-care while valid_o=0.
- Occupancy update each cycle:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
  - Occupancy never leaves the range 0..BUFFER_DEPTH.
- Pointers wrap explicitly: at BUFFER_DEPTH-1 the next value is 0. No modulo-2^n arithmetic, because depth need not be a power of two.
- Watermarks are combinational from the registered count:
  - afull_thr_i=0 forces almost_full_o=1.
  - aempty_thr_i >= BUFFER_DEPTH forces almost_empty_o=1.
  - Thresholds are compared unsigned at CNT_W bits.
- overflow_o sets on valid_i && full. It is cleared by clr_i or ovf_clr_i. If set and clear happen in the same cycle, set wins.
- clr_i:
  - Next cycle: pointers=0, count=0, overflow_o=0, peak_o=0.
  - Any push or pop in the clear cycle is discarded.
  - clr_i has priority over everything except rst_ni.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronous). There is no residual valid_o.

Optional Feature:
- Macro SPI_FIFO_PEAK_EN.
- Defined:
  - peak_o holds the maximum elements_o observed since reset/clr_i.
  - Updated one cycle after elements_o exceeds it; saturates at BUFFER_DEPTH.
- Undefined:
  - peak_o port is absent and no tracking register is built.
  - All other behaviour is identical.

Decomposition:
- Package spi_fifo_pkg holds:
  - typedef enum for count-change {CNT_HOLD, CNT_INC, CNT_DEC}.
  - Function next_ptr(ptr, depth) implementing the wrap rule.
  - Constant SPI_FIFO_MIN_DEPTH=2, checked with an elaboration-time assertion.
- One natural sub-module: spi_fifo_ptr, a wrapping pointer register with enable, sync clear and async reset. It is instantiated twice (read and write).

Test Plan:
- Depth 5, write 5 words 0xA0..0xA4 with ready_i=0:
  - ready_o drops after the 5th write; elements_o=5, free_o=0, almost_full_o=1 with threshold 4.
  - Then read all 5: data order A0..A4; valid_o=0 after the last read.
- Depth 5, 13 words streamed with valid_i=ready_i=1 continuously: pointer wrap past 4 to 0 is correct, no data loss, elements_o stays at or below 1.
- Full FIFO, valid_i=1 and ready_i=1 in the same cycle: push rejected, overflow_o=1, elements_o=4.
  - Then ovf_clr_i with valid_i=0 -> overflow_o=0.
  - Then overflow re-set and ovf_clr_i in the same cycle -> overflow_o stays 1.
- Fill 3 words, assert clr_i together with valid_i:
  - Next cycle elements_o=0, valid_o=0, overflow_o=0.
  - A following write of 0x55 reads back as 0x55.
- Fill 3 words, pulse rst_ni low mid-cycle: outputs are at reset values before the next clock edge.
- Threshold sweep, aempty_thr_i=2 and afull_thr_i=6 on depth 8: almost_empty_o is high for counts 0..2, almost_full_o is high for 6..8. With SPI_FIFO_PEAK_EN, peak_o=8 after the fill-and-drain.
